// File: rtl/serial_deserializer_d_pkg.sv
// Shared types and constants for the serial deserializer.
package serial_deserializer_d_pkg;

  // Default word length in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Widest word the debug view can carry, and the matching counter width.
  localparam int DBG_SR_W  = 16;
  localparam int DBG_CNT_W = 5;

  // Frame state: IDLE waits for a start, SHIFT is collecting bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Internal state made visible for checkers and debug.
  typedef struct packed {
    state_e                 state;
    logic [DBG_CNT_W-1:0]   cnt;
    logic [DBG_SR_W-1:0]    sr;
  } dbg_t;

  // Bit counter width: wide enough to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/flipflop_d_arst.sv
// D flip-flop with load enable and asynchronous active-low clear.
module flipflop_d_arst (
  input  logic d,
  input  logic en,
  input  logic clk,
  input  logic rst_n,
  output logic q,
  output logic q_inverse
);

  // Storage: clear on reset, load d when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

  assign q_inverse = ~q;

endmodule

// File: rtl/serial_deserializer_d.sv
// Serial-to-parallel converter with frame sync, gap tolerance and abort
// detection. Datapath is a chain of enable flops; control is behavioural.
//
// Handshake: din/start are consumed only on rising edges where din_valid is
// high; there is no back-pressure. dout_valid and frame_err are single-cycle
// registered pulses; dout holds the last completed word until replaced.
module serial_deserializer_d
  import serial_deserializer_d_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err,
  output dbg_t             dbg
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;

  logic [WIDTH-1:0] sr_q, sr_qn, sr_d;
  logic             sr_en;
  logic [WIDTH-1:0] sr_shift, sr_first;

  // Shift register: one enable flop per bit, all loaded together.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sr
    flipflop_d_arst u_ff (
      .d         (sr_d[i]),
      .en        (sr_en),
      .clk       (clk),
      .rst_n     (rst_n),
      .q         (sr_q[i]),
      .q_inverse (sr_qn[i])
    );
  end

  // Candidate shift-register values: continue a frame, or begin a fresh one
  // with only the new bit present so no stale bits survive an abort.
  always_comb begin
    sr_shift = sr_q;
    sr_first = '0;
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-2:0], din};
      sr_first = {{(WIDTH-1){1'b0}}, din};
    end else begin
      sr_shift = {din, sr_q[WIDTH-1:1]};
      sr_first = {din, {(WIDTH-1){1'b0}}};
    end
  end

  // Next-state and output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    sr_en        = 1'b0;
    sr_d         = sr_shift;
    unique case (state_q)
      ST_IDLE: begin
        if (din_valid && start) begin
          sr_en   = 1'b1;
          sr_d    = sr_first;
          cnt_d   = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (din_valid) begin
          sr_en = 1'b1;
          if (start) begin
            // New sync inside a frame: drop the partial word and restart.
            sr_d        = sr_first;
            cnt_d       = CW'(1);
            frame_err_d = 1'b1;
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            // This edge samples the last bit; publish the whole word now.
            dout_d       = sr_shift;
            dout_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

  // Debug view; the register image is rebuilt from the complementary flop
  // outputs so both outputs of every cell are observable.
  always_comb begin
    dbg       = '0;
    dbg.state = state_q;
    dbg.cnt   = DBG_CNT_W'(cnt_q);
    dbg.sr    = DBG_SR_W'(~sr_qn);
  end

endmodule

// File: tb/tb_serial_deserializer_d.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share one
// stimulus stream; drivers push expected words/cycles, monitors pop.
module tb_serial_deserializer_d;
  import serial_deserializer_d_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic start = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_dout, l_dout;
  logic       m_dv, l_dv, m_busy, l_busy, m_ferr, l_ferr;
  dbg_t       m_dbg, l_dbg;

  serial_deserializer_d #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
    .dout(m_dout), .dout_valid(m_dv), .busy(m_busy), .frame_err(m_ferr),
    .dbg(m_dbg)
  );

  serial_deserializer_d #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
    .dout(l_dout), .dout_valid(l_dv), .busy(l_busy), .frame_err(l_ferr),
    .dbg(l_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];
  int         cyc_m_q[$];
  int         cyc_l_q[$];
  int         ferr_m_q[$];
  int         ferr_l_q[$];
  bit         partial_open = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_dv) begin
      if (exp_m_q.size() == 0) check("msb_unexpected_valid", 32'(exp_m_q.size()), 32'd1);
      else begin
        check("msb_dout", 32'(m_dout), 32'(exp_m_q.pop_front()));
        check("msb_valid_cycle", 32'(cyc), 32'(cyc_m_q.pop_front()));
      end
    end
    if (l_dv) begin
      if (exp_l_q.size() == 0) check("lsb_unexpected_valid", 32'(exp_l_q.size()), 32'd1);
      else begin
        check("lsb_dout", 32'(l_dout), 32'(exp_l_q.pop_front()));
        check("lsb_valid_cycle", 32'(cyc), 32'(cyc_l_q.pop_front()));
      end
    end
    if (m_ferr) begin
      if (ferr_m_q.size() == 0) check("msb_unexpected_ferr", 32'(ferr_m_q.size()), 32'd1);
      else check("msb_ferr_cycle", 32'(cyc), 32'(ferr_m_q.pop_front()));
    end
    if (l_ferr) begin
      if (ferr_l_q.size() == 0) check("lsb_unexpected_ferr", 32'(ferr_l_q.size()), 32'd1);
      else check("lsb_ferr_cycle", 32'(cyc), 32'(ferr_l_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic b);
    din_valid = v;
    start     = s;
    din       = b;
    @(posedge clk);
    #1;
  endtask

  // Sends the 8 bits of w, most significant first, with start on bit 0.
  // gap_at >= 0 inserts 3 invalid cycles after that bit index.
  task automatic send_word(input logic [7:0] w, input logic [7:0] exp_m,
                           input logic [7:0] exp_l, input int gap_at);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, w[7-i]);
      if (i == 0) begin
        if (partial_open) begin
          ferr_m_q.push_back(cyc);
          ferr_l_q.push_back(cyc);
          partial_open = 1'b0;
        end
        check("busy_after_start", {30'd0, m_busy, l_busy}, 32'd3);
      end
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("busy_during_gap", {30'd0, m_busy, l_busy}, 32'd3);
      end
      if (i == 7) begin
        exp_m_q.push_back(exp_m);
        exp_l_q.push_back(exp_l);
        cyc_m_q.push_back(cyc);
        cyc_l_q.push_back(cyc);
      end
    end
    check("busy_after_word", {30'd0, m_busy, l_busy}, 32'd0);
  endtask

  // Sends the first n bits of w with start on bit 0, leaving the frame open.
  task automatic send_partial(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, i == 0, w[7-i]);
    partial_open = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", {m_dout, l_dout}, 32'd0);
    check("reset_flags", {26'd0, m_dv, l_dv, m_busy, l_busy, m_ferr, l_ferr}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("post_reset_flags", {26'd0, m_dv, l_dv, m_busy, l_busy, m_ferr, l_ferr}, 32'd0);

    // Bits without start in IDLE are ignored.
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check("idle_discard_busy", {30'd0, m_busy, l_busy}, 32'd0);

    // Single frame 1,0,1,0,0,1,0,1.
    send_word(8'hA5, 8'hA5, 8'hA5, -1);
    drive(1'b0, 1'b0, 1'b0);

    // Same bits with a 3-cycle gap after the 4th bit.
    send_word(8'hA5, 8'hA5, 8'hA5, 3);

    // Non-palindromic word exercises bit order: 1100_0100 vs reversed 0010_0011.
    send_word(8'hC4, 8'hC4, 8'h23, -1);

    // dout holds through idle traffic.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check("dout_hold", {m_dout, l_dout}, {16'd0, 8'hC4, 8'h23});

    // Abort: 5 bits, then a new start with 8'h3C.
    send_partial(8'hB7, 5);
    send_word(8'h3C, 8'h3C, 8'h3C, -1);

    // Back-to-back frames, no idle edge between them.
    send_word(8'hFF, 8'hFF, 8'hFF, -1);
    send_word(8'h01, 8'h01, 8'h80, -1);
    drive(1'b0, 1'b0, 1'b0);

    // Mid-frame asynchronous reset after 3 bits.
    send_partial(8'hC3, 3);
    din_valid = 1'b0;
    start     = 1'b0;
    #3;
    rst_n = 1'b0;
    partial_open = 1'b0;
    #1;
    check("arst_dout", {m_dout, l_dout}, 32'd0);
    check("arst_flags", {26'd0, m_dv, l_dv, m_busy, l_busy, m_ferr, l_ferr}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("post_arst_busy", {30'd0, m_busy, l_busy}, 32'd0);

    // Normal operation after reset.
    send_word(8'h5A, 8'h5A, 8'h5A, -1);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
    check("pending_words", 32'(exp_m_q.size() + exp_l_q.size()), 32'd0);
    check("pending_ferr", 32'(ferr_m_q.size() + ferr_l_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_deserializer_d.md
SERIAL_DESERIALIZER_D -- requirements
Module: serial_deserializer_d

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the word length in bits; legal range is 2..16.
REQ-002 The block SHALL have the parameter MSB_FIRST, default 1; 1 means the first serial bit lands in dout[WIDTH-1], 0 means it lands in dout[0].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port din, input, 1 bit: the serial data bit, normally driven by an upstream D flip-flop q.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din is sampled only on edges where this is high.
REQ-007 The block SHALL have port start, input, 1 bit: frame sync, qualified by din_valid; marks din as bit 0 of a new word.
REQ-008 The block SHALL have port dout, output, WIDTH bits: the last completed word.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: one-cycle pulse when dout is updated.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is partially received.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted by a new start.

Function
REQ-012 The block SHALL use two states: IDLE (busy=0) and SHIFT (busy=1).
REQ-013 In IDLE, an edge with din_valid=1 and start=1 SHALL capture din as bit 0, set the bit count to 1, and enter SHIFT.
REQ-014 In IDLE, an edge with din_valid=1 and start=0 SHALL discard din with no state change.
REQ-015 In SHIFT, an edge with din_valid=0 SHALL hold all state; gaps of any length are allowed.
REQ-016 In SHIFT, an edge with din_valid=1 and start=0 SHALL shift din into the shift register and increment the bit count.
REQ-017 When the edge in REQ-016 samples bit WIDTH-1, that same edge SHALL load dout with the complete word, set dout_valid=1, and return to IDLE.
REQ-018 dout_valid SHALL be high for exactly one cycle per completed word.
REQ-019 dout SHALL hold its value until the next completed word.
REQ-020 In SHIFT, an edge with din_valid=1 and start=1 SHALL discard the partial word, pulse frame_err for one cycle, capture din as bit 0 of a new frame (count=1), and stay in SHIFT.
REQ-021 On such an abort, dout and dout_valid SHALL be unaffected.
REQ-022 Back-to-back frames SHALL be supported: a start on the edge immediately after a completing edge is accepted, giving a sustained throughput of one word per WIDTH valid cycles.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and never exceed WIDTH-1 while in SHIFT.
REQ-024 Bit ordering SHALL follow MSB_FIRST exactly, with no other reordering.
REQ-025 dout, dout_valid, busy, and frame_err SHALL all be registered outputs.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force IDLE, shift register=0, count=0, dout=0, dout_valid=0, busy=0, and frame_err=0, independent of clk.
REQ-027 Reset asserted mid-frame SHALL discard the partial word with no dout_valid and no frame_err.
REQ-028 The first edge after rst_n rises SHALL be treated as a normal IDLE edge.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, SHIFT), the default WIDTH constant, and a helper function returning the counter width.
REQ-030 The shift register SHALL be built from WIDTH instances of the sub-module flipflop_d_arst (ports d, en, clk, rst_n, q, q_inverse), a D flip-flop with enable and asynchronous active-low clear.
REQ-031 Control (FSM, counter, output registers) SHALL be behavioural logic in serial_deserializer_d.

Verification
REQ-032 Reset check: hold rst_n=0 for 3 cycles, release -> dout=8'h00, dout_valid=0, busy=0, frame_err=0.
REQ-033 Single-frame check: WIDTH=8, MSB_FIRST=1, start with stream 1,0,1,0,0,1,0,1 on consecutive valid cycles -> dout=8'hA5 with dout_valid high for one cycle on the 8th edge and busy low afterwards.
REQ-034 Gap and ordering check: same bits with MSB_FIRST=0 and din_valid low for 3 cycles after bit 4 -> dout=8'hA5 (bit order reversed, so the result is symmetric to 8'hA5 under LSB-first capture) and no early dout_valid.
REQ-035 Abort check: start, 5 bits, then start with stream 8'h3C -> one frame_err pulse at the second start, then dout=8'h3C with a single dout_valid.
REQ-036 Back-to-back check: frames 8'hFF then 8'h01 with no idle cycle -> two dout_valid pulses exactly 8 cycles apart and correct values.
REQ-037 Mid-frame reset check: assert rst_n=0 asynchronously after bit 3, then release -> outputs return to reset values immediately and no dout_valid occurs for the partial word.
